// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared memory port.
// Round-robin between the two requesters, with a per-access timeout and a sticky error flag.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDRESS,
    output logic [31:0] I_READ_DATA,
    output logic        I_BUSYWAIT,
    input  logic        D_READ,
    input  logic        D_WRITE,
    input  logic [31:0] D_ADDRESS,
    input  logic [31:0] D_WRITE_DATA,
    output logic [31:0] D_READ_DATA,
    output logic        D_BUSYWAIT,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [31:0] M_ADDRESS,
    output logic [31:0] M_WRITE_DATA,
    input  logic [31:0] M_READ_DATA,
    input  logic        M_ACK,
    output logic        ERROR
);

    typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [8:0]  wait_q, wait_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;
    logic [31:0] m_address_q, m_address_d;
    logic [31:0] m_write_data_q, m_write_data_d;
    logic [31:0] i_read_data_q, i_read_data_d;
    logic [31:0] d_read_data_q, d_read_data_d;
    logic        error_q, error_d;

    logic        grant_i, grant_d;
    logic [8:0]  wait_next;
    logic        timeout_hit;

    // last_d_q set means D won the previous grant, so I wins a tie next time
    assign grant_d     = (D_READ | D_WRITE) & (~I_READ | ~last_d_q);
    assign grant_i     = I_READ & ~grant_d;
    assign wait_next   = wait_q + 9'd1;
    assign timeout_hit = ~M_ACK & (wait_next >= TIMEOUT_W);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            wait_q         <= '0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_write_data_q <= '0;
            i_read_data_q  <= '0;
            d_read_data_q  <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            wait_q         <= wait_d;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_write_data_q <= m_write_data_d;
            i_read_data_q  <= i_read_data_d;
            d_read_data_q  <= d_read_data_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)
                    state_d = D_ACC;
                else if (grant_i)
                    state_d = I_ACC;
            end
            I_ACC:   if (M_ACK || timeout_hit) state_d = I_DONE;
            D_ACC:   if (M_ACK || timeout_hit) state_d = D_DONE;
            I_DONE:  state_d = IDLE;
            D_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side request registers, read-data capture, wait counter and error flag
    always_comb begin
        last_d_d       = last_d_q;
        wait_d         = wait_q;
        m_read_d       = m_read_q;
        m_write_d      = m_write_q;
        m_address_d    = m_address_q;
        m_write_data_d = m_write_data_q;
        i_read_data_d  = i_read_data_q;
        d_read_data_d  = d_read_data_q;
        error_d        = error_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    last_d_d       = 1'b1;
                    wait_d         = '0;
                    m_address_d    = D_ADDRESS;
                    m_write_data_d = D_WRITE_DATA;
                    m_write_d      = D_WRITE;
                    m_read_d       = D_READ & ~D_WRITE;
                    if (D_READ && D_WRITE)
                        error_d = 1'b1;
                end else if (grant_i) begin
                    last_d_d       = 1'b0;
                    wait_d         = '0;
                    m_address_d    = I_ADDRESS;
                    m_write_data_d = '0;
                    m_write_d      = 1'b0;
                    m_read_d       = 1'b1;
                end
            end
            I_ACC, D_ACC: begin
                if (M_ACK) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (state_q == I_ACC)
                        i_read_data_d = M_READ_DATA;
                    else if (!m_write_q)
                        d_read_data_d = M_READ_DATA;
                end else begin
                    wait_d = wait_next;
                    if (timeout_hit) begin
                        m_read_d  = 1'b0;
                        m_write_d = 1'b0;
                        error_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        I_BUSYWAIT = I_READ & (state_q != I_DONE);
        D_BUSYWAIT = (D_READ | D_WRITE) & (state_q != D_DONE);
    end

    assign M_READ       = m_read_q;
    assign M_WRITE      = m_write_q;
    assign M_ADDRESS    = m_address_q;
    assign M_WRITE_DATA = m_write_data_q;
    assign I_READ_DATA  = i_read_data_q;
    assign D_READ_DATA  = d_read_data_q;
    assign ERROR        = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): reset, fetch, round-robin contention,
// store, reset mid-access, illegal request, timeout and stray acks.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_READ;
    logic [31:0] I_ADDRESS;
    logic [31:0] I_READ_DATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [31:0] D_ADDRESS;
    logic [31:0] D_WRITE_DATA;
    logic [31:0] D_READ_DATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDRESS;
    logic [31:0] M_WRITE_DATA;
    logic [31:0] M_READ_DATA;
    logic        M_ACK;
    logic        ERROR;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READ_DATA(I_READ_DATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITE_DATA(D_WRITE_DATA),
        .D_READ_DATA(D_READ_DATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITE_DATA(M_WRITE_DATA),
        .M_READ_DATA(M_READ_DATA), .M_ACK(M_ACK), .ERROR(ERROR)
    );

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1; I_READ = 1'b1; I_ADDRESS = '0; D_READ = 1'b0; D_WRITE = 1'b0;
        D_ADDRESS = '0; D_WRITE_DATA = '0; M_READ_DATA = '0; M_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({M_READ, M_WRITE, ERROR} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {M_READ, M_WRITE, ERROR});
        end
        checks++;
        if ({M_ADDRESS, M_WRITE_DATA} !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_maddr: got %h expected 0", {M_ADDRESS, M_WRITE_DATA});
        end
        checks++;
        if ({I_READ_DATA, D_READ_DATA} !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", {I_READ_DATA, D_READ_DATA});
        end
        checks++;
        if ({I_BUSYWAIT, D_BUSYWAIT} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_busywait: got %b expected 10", {I_BUSYWAIT, D_BUSYWAIT});
        end
        I_READ = 1'b0;
        RESET  = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single_fetch();
        I_READ = 1'b1; I_ADDRESS = 32'h0000_0010;
        #1;
        checks++;
        if ({I_BUSYWAIT, M_READ} !== 2'b10) begin
            errors++; $display("[TB] FAIL fetch_idle: got %b expected 10", {I_BUSYWAIT, M_READ});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if ({I_BUSYWAIT, M_READ, M_WRITE, M_ADDRESS} !== {3'b110, 32'h0000_0010}) begin
                errors++;
                $display("[TB] FAIL fetch_acc%0d: got %b/%h expected 110/00000010", c,
                         {I_BUSYWAIT, M_READ, M_WRITE}, M_ADDRESS);
            end
            if (c == 2) begin
                M_ACK = 1'b1; M_READ_DATA = 32'h0050_0093;
            end
        end
        @(negedge CLK);
        M_ACK = 1'b0;
        checks++;
        if ({I_BUSYWAIT, M_READ, I_READ_DATA} !== {2'b00, 32'h0050_0093}) begin
            errors++;
            $display("[TB] FAIL fetch_done: got %b/%h expected 00/00500093", {I_BUSYWAIT, M_READ}, I_READ_DATA);
        end
        @(negedge CLK);
        checks++;
        if ({I_BUSYWAIT, M_READ} !== 2'b10) begin
            errors++; $display("[TB] FAIL fetch_after_done: got %b expected 10", {I_BUSYWAIT, M_READ});
        end
        I_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_contention();
        logic        exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] i_addr, d_addr, exp_addr, data;
        do_reset();
        i_addr = 32'h20; d_addr = 32'h100;
        I_READ = 1'b1; I_ADDRESS = i_addr; D_READ = 1'b1; D_ADDRESS = d_addr;
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 6 && M_READ !== 1'b1; n++) @(negedge CLK);
            exp_addr = exp_d[g] ? d_addr : i_addr;
            data     = 32'hA000_0000 + 32'(g);
            checks++;
            if ({M_READ, M_ADDRESS} !== {1'b1, exp_addr}) begin
                errors++;
                $display("[TB] FAIL grant%0d: got %b/%h expected 1/%h", g, M_READ, M_ADDRESS, exp_addr);
            end
            @(negedge CLK);
            checks++;
            if ({M_READ, M_ADDRESS} !== {1'b1, exp_addr}) begin
                errors++;
                $display("[TB] FAIL grant%0d_hold: got %b/%h expected 1/%h", g, M_READ, M_ADDRESS, exp_addr);
            end
            M_ACK = 1'b1; M_READ_DATA = data;
            @(negedge CLK);
            M_ACK = 1'b0;
            checks++;
            if (exp_d[g]) begin
                if ({D_BUSYWAIT, I_BUSYWAIT, D_READ_DATA} !== {2'b01, data}) begin
                    errors++;
                    $display("[TB] FAIL grant%0d_done: got %b/%h expected 01/%h", g,
                             {D_BUSYWAIT, I_BUSYWAIT}, D_READ_DATA, data);
                end
                d_addr = d_addr + 32'h4; D_ADDRESS = d_addr;
            end else begin
                if ({D_BUSYWAIT, I_BUSYWAIT, I_READ_DATA} !== {2'b10, data}) begin
                    errors++;
                    $display("[TB] FAIL grant%0d_done: got %b/%h expected 10/%h", g,
                             {D_BUSYWAIT, I_BUSYWAIT}, I_READ_DATA, data);
                end
                i_addr = i_addr + 32'h4; I_ADDRESS = i_addr;
            end
        end
        I_READ = 1'b0; D_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_store();
        D_WRITE = 1'b1; D_ADDRESS = 32'h200; D_WRITE_DATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        checks++;
        if ({M_WRITE, M_READ, D_BUSYWAIT, M_ADDRESS, M_WRITE_DATA} !== {3'b101, 32'h200, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL store_acc: got %b/%h/%h expected 101/00000200/deadbeef",
                     {M_WRITE, M_READ, D_BUSYWAIT}, M_ADDRESS, M_WRITE_DATA);
        end
        M_ACK = 1'b1; M_READ_DATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        M_ACK = 1'b0;
        checks++;
        if ({D_BUSYWAIT, M_WRITE, D_READ_DATA, I_READ_DATA} !== {2'b00, 32'hA000_0002, 32'hA000_0003}) begin
            errors++;
            $display("[TB] FAIL store_done: got %b/%h/%h expected 00/a0000002/a0000003",
                     {D_BUSYWAIT, M_WRITE}, D_READ_DATA, I_READ_DATA);
        end
        @(negedge CLK);
        checks++;
        if ({D_BUSYWAIT, ERROR} !== 2'b10) begin
            errors++; $display("[TB] FAIL store_after_done: got %b expected 10", {D_BUSYWAIT, ERROR});
        end
        D_WRITE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_access();
        D_READ = 1'b1; D_ADDRESS = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({M_READ, M_ADDRESS} !== {1'b1, 32'h300}) begin
            errors++; $display("[TB] FAIL midrst_acc: got %b/%h expected 1/00000300", M_READ, M_ADDRESS);
        end
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if ({M_READ, M_WRITE, ERROR, M_ADDRESS, M_WRITE_DATA, I_READ_DATA, D_READ_DATA} !== 131'h0) begin
            errors++;
            $display("[TB] FAIL midrst_zero: got %b/%h/%h/%h/%h expected all zero", {M_READ, M_WRITE, ERROR},
                     M_ADDRESS, M_WRITE_DATA, I_READ_DATA, D_READ_DATA);
        end
        checks++;
        if (D_BUSYWAIT !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_busywait: got %b expected 1", D_BUSYWAIT);
        end
        RESET = 1'b0; D_READ = 1'b0; M_ACK = 1'b1; M_READ_DATA = 32'h1234_5678;
        @(negedge CLK);
        M_ACK = 1'b0;
        checks++;
        if ({M_READ, D_BUSYWAIT, D_READ_DATA} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL midrst_late_ack: got %b/%h expected 00/00000000", {M_READ, D_BUSYWAIT}, D_READ_DATA);
        end
    endtask

    task automatic test_illegal();
        D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 32'h400; D_WRITE_DATA = 32'h55;
        #1;
        checks++;
        if (ERROR !== 1'b0) begin
            errors++; $display("[TB] FAIL illegal_pre: got %b expected 0", ERROR);
        end
        @(negedge CLK);
        checks++;
        if ({M_WRITE, M_READ, ERROR} !== 3'b101) begin
            errors++; $display("[TB] FAIL illegal_acc: got %b expected 101", {M_WRITE, M_READ, ERROR});
        end
        M_ACK = 1'b1; M_READ_DATA = 32'h77;
        @(negedge CLK);
        M_ACK = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        checks++;
        if ({ERROR, D_READ_DATA} !== {1'b1, 32'h0}) begin
            errors++; $display("[TB] FAIL illegal_done: got %b/%h expected 1/00000000", ERROR, D_READ_DATA);
        end
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int acc_cycles;
        do_reset();
        checks++;
        if (ERROR !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_pre: got %b expected 0", ERROR);
        end
        I_READ = 1'b1; I_ADDRESS = 32'h40;
        acc_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (M_READ !== 1'b1) break;
            acc_cycles++;
        end
        checks++;
        if (acc_cycles !== 4) begin
            errors++; $display("[TB] FAIL timeout_cycles: got %0d expected 4", acc_cycles);
        end
        checks++;
        if ({I_BUSYWAIT, ERROR, I_READ_DATA} !== {2'b01, 32'h0}) begin
            errors++;
            $display("[TB] FAIL timeout_done: got %b/%h expected 01/00000000", {I_BUSYWAIT, ERROR}, I_READ_DATA);
        end
        I_READ = 1'b0;
        @(negedge CLK);
        M_ACK = 1'b1; M_READ_DATA = 32'hCAFE_F00D;
        @(negedge CLK);
        M_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({M_READ, ERROR, I_READ_DATA, D_READ_DATA} !== {2'b01, 64'h0}) begin
            errors++;
            $display("[TB] FAIL idle_ack_sticky: got %b/%h/%h expected 01/0/0", {M_READ, ERROR}, I_READ_DATA, D_READ_DATA);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (ERROR !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", ERROR);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_reset_mid_access();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
